spi_target_frontend: RTL and testbench

//  SPI target (mode 0, MSB first) front end between the nRF host and the per-block register files.

---
 rtl/spi_target_frontend_if.sv | 27 ++
 rtl/spi_target_frontend.sv | 154 +++++++++++++++
 tb/tb_spi_target_frontend.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_target_frontend_if.sv
// Pin and register-file bundle for the SPI target front end.
// slave = the front end itself, master = host pins plus register-file side.
interface spi_target_frontend_if;
   logic        spi_sclk_in;
   logic        spi_select_n_in;
   logic        spi_copi_in;
   logic        spi_cipo_out;
   logic [7:0]  op_code_out;
   logic        op_code_valid_out;
   logic [7:0]  operand_out;
   logic        operand_valid_out;
   logic [31:0] operand_count_out;
   logic [7:0]  response_in;
   logic        response_valid_in;

   modport slave (
      input  spi_sclk_in, spi_select_n_in, spi_copi_in, response_in, response_valid_in,
      output spi_cipo_out, op_code_out, op_code_valid_out, operand_out, operand_valid_out,
             operand_count_out
   );

   modport master (
      output spi_sclk_in, spi_select_n_in, spi_copi_in, response_in, response_valid_in,
      input  spi_cipo_out, op_code_out, op_code_valid_out, operand_out, operand_valid_out,
             operand_count_out
   );
endinterface

// File: rtl/spi_target_frontend.sv
// SPI mode-0 target front end: oversampled SCK/CS/COPI, op-code/operand deserialiser,
// CIPO serialiser fed by the register-file response selected at each byte boundary.
module spi_target_frontend #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   spi_target_frontend_if.slave  bus
);
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, OPCODE, OPERAND} state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, copi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  op_code_q, op_code_d;
   logic        op_valid_q, op_valid_d;
   logic [7:0]  operand_q, operand_d;
   logic        operand_valid_q, operand_valid_d;
   logic [31:0] count_q, count_d;
   logic [7:0]  cipo_sr_q, cipo_sr_d;
   logic        cipo_q, cipo_d;
   logic        boundary_q, boundary_d;

   logic sclk_s, cs_s, copi_s;
   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic [7:0] rx_byte, resp_sel;

   assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign copi_s   = copi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sclk_s & ~sclk_prev_q;
   assign sck_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign rx_byte  = {shift_q[6:0], copi_s};
   assign resp_sel = bus.response_valid_in ? bus.response_in : 8'h00;

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         sclk_sync_q     <= '0;
         cs_sync_q       <= '0;
         copi_sync_q     <= '0;
         sclk_prev_q     <= 1'b0;
         cs_prev_q       <= 1'b0;
         state_q         <= WAIT_IDLE;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         op_code_q       <= '0;
         op_valid_q      <= 1'b0;
         operand_q       <= '0;
         operand_valid_q <= 1'b0;
         count_q         <= '0;
         cipo_sr_q       <= '0;
         cipo_q          <= 1'b0;
         boundary_q      <= 1'b0;
      end else begin
         sclk_sync_q     <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk_in};
         cs_sync_q       <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_select_n_in};
         copi_sync_q     <= {copi_sync_q[SYNC_STAGES-2:0], bus.spi_copi_in};
         sclk_prev_q     <= sclk_s;
         cs_prev_q       <= cs_s;
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         op_code_q       <= op_code_d;
         op_valid_q      <= op_valid_d;
         operand_q       <= operand_d;
         operand_valid_q <= operand_valid_d;
         count_q         <= count_d;
         cipo_sr_q       <= cipo_sr_d;
         cipo_q          <= cipo_d;
         boundary_q      <= boundary_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      shift_d         = shift_q;
      op_code_d       = op_code_q;
      op_valid_d      = op_valid_q;
      operand_d       = operand_q;
      operand_valid_d = operand_valid_q;
      count_d         = count_q;
      cipo_sr_d       = cipo_sr_q;
      cipo_d          = cipo_q;
      boundary_d      = boundary_q;

      case (state_q)
         // Only arm after seeing CS high, so a reset mid-transfer never joins it halfway.
         WAIT_IDLE: if (cs_s) state_d = IDLE;
         IDLE: begin
            if (cs_fall) begin
               state_d    = OPCODE;
               bit_cnt_d  = '0;
               shift_d    = '0;
               count_d    = '0;
               cipo_sr_d  = '0;
               cipo_d     = 1'b0;
               boundary_d = 1'b0;
            end
         end
         default: begin
            if (cs_rise) begin
               state_d         = IDLE;
               bit_cnt_d       = '0;
               shift_d         = '0;
               op_valid_d      = 1'b0;
               operand_valid_d = 1'b0;
               count_d         = '0;
               cipo_sr_d       = '0;
               cipo_d          = 1'b0;
               boundary_d      = 1'b0;
            end else if (sck_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = 3'(bit_cnt_q + 3'd1);
               if (state_q == OPERAND && bit_cnt_q == 3'd0) operand_valid_d = 1'b0;
               if (bit_cnt_q == 3'd7) begin
                  boundary_d = 1'b1;
                  if (state_q == OPCODE) begin
                     op_code_d  = rx_byte;
                     op_valid_d = 1'b1;
                     state_d    = OPERAND;
                  end else begin
                     operand_d       = rx_byte;
                     operand_valid_d = 1'b1;
                     if (count_q != '1) count_d = count_q + 32'd1;
                  end
               end
            end else if (sck_fall) begin
               // First fall after a byte completes loads the response for the next byte.
               if (boundary_q) begin
                  cipo_sr_d  = resp_sel;
                  cipo_d     = resp_sel[7];
                  boundary_d = 1'b0;
               end else begin
                  cipo_sr_d = {cipo_sr_q[6:0], 1'b0};
                  cipo_d    = cipo_sr_q[6];
               end
            end
         end
      endcase
   end

   assign bus.spi_cipo_out      = cipo_q;
   assign bus.op_code_out       = op_code_q;
   assign bus.op_code_valid_out = op_valid_q;
   assign bus.operand_out       = operand_q;
   assign bus.operand_valid_out = operand_valid_q;
   assign bus.operand_count_out = count_q;
endmodule

// File: tb/tb_spi_target_frontend.sv
// Directed bench for spi_target_frontend: host-side SPI bit-banging with a small
// response table indexed by operand_count_out standing in for a register file.
module tb_spi_target_frontend;
   localparam int SYNC_STAGES = 2;

   logic clock_in = 1'b0;
   logic reset_in = 1'b1;
   spi_target_frontend_if bus();

   spi_target_frontend #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .bus      (bus)
   );

   always #5 clock_in = ~clock_in;

   int         n_chk = 0;
   int         n_err = 0;
   int         half  = 8;
   int         ov_rises = 0;
   int         base;
   logic       ov_prev = 1'b0;
   logic       rv_en;
   logic [7:0] tab [4];
   logic [7:0] rx, rx0, rx1, rx2;

   always_comb begin
      bus.response_in       = (bus.operand_count_out < 32'd4) ? tab[bus.operand_count_out[1:0]] : 8'h00;
      bus.response_valid_in = rv_en;
   end

   always @(posedge clock_in) begin
      ov_prev <= bus.operand_valid_out;
      if (bus.operand_valid_out && !ov_prev) ov_rises <= ov_rises + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   // Mode 0: COPI set while SCK low, host samples CIPO just before raising SCK.
   task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb, input int nbits = 8);
      rxb = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         bus.spi_copi_in = tx[7-i];
         tick(half);
         rxb[7-i] = bus.spi_cipo_out;
         bus.spi_sclk_in = 1'b1;
         tick(half);
         bus.spi_sclk_in = 1'b0;
      end
   endtask

   task automatic cs_set(input logic v, input int settle);
      bus.spi_select_n_in = v;
      tick(settle);
   endtask

   initial begin
      bus.spi_sclk_in     = 1'b0;
      bus.spi_select_n_in = 1'b1;
      bus.spi_copi_in     = 1'b0;
      rv_en               = 1'b1;
      for (int i = 0; i < 4; i++) tab[i] = 8'h00;
      tick(3);
      chk("rst_opv",   {31'd0, bus.op_code_valid_out}, 32'd0);
      chk("rst_op",    {24'd0, bus.op_code_out}, 32'd0);
      chk("rst_ov",    {31'd0, bus.operand_valid_out}, 32'd0);
      chk("rst_cnt",   bus.operand_count_out, 32'd0);
      chk("rst_cipo",  {31'd0, bus.spi_cipo_out}, 32'd0);
      reset_in = 1'b0;
      tick(6);

      // 1: op 0x21 with two dummy bytes, responses 0x12 / 0x34
      tab[0] = 8'h12; tab[1] = 8'h34;
      cs_set(1'b0, 6);
      xfer(8'h21, rx0); xfer(8'h00, rx1); xfer(8'h00, rx2);
      tick(6);
      chk("t1_op",   {24'd0, bus.op_code_out}, 32'h21);
      chk("t1_opv",  {31'd0, bus.op_code_valid_out}, 32'd1);
      chk("t1_rx0",  {24'd0, rx0}, 32'h00);
      chk("t1_rx1",  {24'd0, rx1}, 32'h12);
      chk("t1_rx2",  {24'd0, rx2}, 32'h34);
      chk("t1_cnt",  bus.operand_count_out, 32'd2);
      cs_set(1'b1, SYNC_STAGES + 2);
      chk("t1_rel_opv", {31'd0, bus.op_code_valid_out}, 32'd0);
      chk("t1_rel_ov",  {31'd0, bus.operand_valid_out}, 32'd0);
      chk("t1_rel_cnt", bus.operand_count_out, 32'd0);
      tick(4);

      // 2: op 0x26, operand 0x05
      base = ov_rises;
      cs_set(1'b0, 6);
      xfer(8'h26, rx); xfer(8'h05, rx);
      tick(6);
      chk("t2_operand", {24'd0, bus.operand_out}, 32'h05);
      chk("t2_ov",      {31'd0, bus.operand_valid_out}, 32'd1);
      chk("t2_rises",   ov_rises - base, 32'd1);
      chk("t2_cnt",     bus.operand_count_out, 32'd1);
      cs_set(1'b1, SYNC_STAGES + 2);
      chk("t2_rel_opv", {31'd0, bus.op_code_valid_out}, 32'd0);
      chk("t2_rel_ov",  {31'd0, bus.operand_valid_out}, 32'd0);
      tick(4);

      // 3: op 0x22 with four operand bytes, distinct responses per count
      tab[0] = 8'hA1; tab[1] = 8'hB2; tab[2] = 8'hC3; tab[3] = 8'hD4;
      base = ov_rises;
      cs_set(1'b0, 6);
      xfer(8'h22, rx);
      xfer(8'h10, rx); chk("t3_cnt1", bus.operand_count_out, 32'd1); chk("t3_rx1", {24'd0, rx}, 32'hA1);
      xfer(8'h20, rx); chk("t3_cnt2", bus.operand_count_out, 32'd2); chk("t3_rx2", {24'd0, rx}, 32'hB2);
      xfer(8'h30, rx); chk("t3_cnt3", bus.operand_count_out, 32'd3); chk("t3_rx3", {24'd0, rx}, 32'hC3);
      xfer(8'h40, rx); chk("t3_cnt4", bus.operand_count_out, 32'd4); chk("t3_rx4", {24'd0, rx}, 32'hD4);
      tick(6);
      chk("t3_rises",   ov_rises - base, 32'd4);
      chk("t3_operand", {24'd0, bus.operand_out}, 32'h40);
      cs_set(1'b1, 8);

      // 4: abort three bits into the second operand byte
      base = ov_rises;
      cs_set(1'b0, 6);
      xfer(8'h23, rx); xfer(8'h77, rx);
      tick(6);
      chk("t4_cnt_a", bus.operand_count_out, 32'd1);
      xfer(8'hFF, rx, 3);
      tick(6);
      chk("t4_cnt_b", bus.operand_count_out, 32'd1);
      chk("t4_ov_lo", {31'd0, bus.operand_valid_out}, 32'd0);
      cs_set(1'b1, 8);
      chk("t4_rises",   ov_rises - base, 32'd1);
      chk("t4_operand", {24'd0, bus.operand_out}, 32'h77);
      chk("t4_rel_cnt", bus.operand_count_out, 32'd0);
      cs_set(1'b0, 6);
      xfer(8'h25, rx);
      tick(6);
      chk("t4_op2",   {24'd0, bus.op_code_out}, 32'h25);
      chk("t4_cnt0",  bus.operand_count_out, 32'd0);
      xfer(8'h01, rx);
      tick(6);
      chk("t4_cnt1",  bus.operand_count_out, 32'd1);
      cs_set(1'b1, 8);

      // 5: reset mid op-code must not let the front end join the running transfer
      cs_set(1'b0, 6);
      xfer(8'hA5, rx, 4);
      reset_in = 1'b1;
      tick(2);
      chk("t5_rst_opv", {31'd0, bus.op_code_valid_out}, 32'd0);
      chk("t5_rst_op",  {24'd0, bus.op_code_out}, 32'd0);
      reset_in = 1'b0;
      xfer(8'h50, rx, 4);
      xfer(8'h21, rx);
      tick(6);
      chk("t5_no_opv", {31'd0, bus.op_code_valid_out}, 32'd0);
      chk("t5_no_op",  {24'd0, bus.op_code_out}, 32'd0);
      cs_set(1'b1, 8);
      cs_set(1'b0, 6);
      xfer(8'h20, rx);
      tick(6);
      chk("t5_op",  {24'd0, bus.op_code_out}, 32'h20);
      chk("t5_opv", {31'd0, bus.op_code_valid_out}, 32'd1);
      cs_set(1'b1, 8);

      // 6: fastest SCK; invalid response sends zeros, valid one goes out intact
      half = 6;
      for (int i = 0; i < 4; i++) tab[i] = 8'hFF;
      rv_en = 1'b0;
      cs_set(1'b0, 6);
      xfer(8'h30, rx); xfer(8'h00, rx);
      chk("t6_rx_inval", {24'd0, rx}, 32'h00);
      cs_set(1'b1, 8);
      rv_en  = 1'b1;
      tab[0] = 8'h5A;
      cs_set(1'b0, 6);
      xfer(8'h31, rx); xfer(8'h9C, rx);
      chk("t6_rx_val", {24'd0, rx}, 32'h5A);
      tick(6);
      chk("t6_operand", {24'd0, bus.operand_out}, 32'h9C);
      chk("t6_op",      {24'd0, bus.op_code_out}, 32'h31);
      cs_set(1'b1, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
